hcp_input_arbiter: RTL

//  Packet-level round-robin arbiter sharing one 9-bit HCP byte-stream input (the byte-to-134b width

---
 rtl/hcp_input_arbiter.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/hcp_input_arbiter.sv
// hcp_input_arbiter
//   Packet-level round-robin arbiter that shares one 9-bit HCP byte-stream
//   input (the byte-to-134b width transform) among NUM_PORTS sources. One
//   source is granted per packet and its bytes are muxed to the transform.
//   Bit 8 marks the start byte and the last byte of a packet. After the start
//   byte, the packet carries metadata up to META_BYTES bytes (the start byte
//   counts as one of them). Any bytes after that are data.
//
//   Optional feature macro: ARB_WATCHDOG_EN
//     When this macro is defined, a watchdog closes a stalled packet after
//     TIMEOUT idle cycles. It pads any missing metadata with 9'h000 and then
//     appends a 9'h100 last byte, so the transform always returns to idle.
//     When the macro is undefined, a stalled source keeps the grant
//     indefinitely and o_flush_pulse is tied to 0.
//
// Ports
//   i_clk          clock
//   i_rst_n        asynchronous reset, active-low
//   iv_req         per-source packet request (level)
//   ov_grant       one-hot grant (registered)
//   iv_data        source bytes, source k on [9k+8:9k]
//   iv_data_wr     per-source byte valid
//   ov_data        muxed byte to the transform (registered, 1-cycle lag)
//   o_data_wr      byte valid to the transform
//   ov_pkt_cnt     packets forwarded, including flushed packets (wraps)
//   ov_drop_cnt    bytes dropped (saturates at 16'hFFFF)
//   o_flush_pulse  one-cycle pulse when a watchdog flush starts
module hcp_input_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int META_BYTES = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_PORTS-1:0]   iv_req,
  output logic [NUM_PORTS-1:0]   ov_grant,
  input  logic [9*NUM_PORTS-1:0] iv_data,
  input  logic [NUM_PORTS-1:0]   iv_data_wr,
  output logic [8:0]             ov_data,
  output logic                   o_data_wr,
  output logic [31:0]            ov_pkt_cnt,
  output logic [15:0]            ov_drop_cnt,
  output logic                   o_flush_pulse
);

  localparam int IDX_W  = $clog2(NUM_PORTS);
  localparam int MCNT_W = $clog2(META_BYTES + 1);
  localparam int DCNT_W = $clog2(NUM_PORTS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_META,
    S_DATA,
    S_FLUSH,
    S_GAP
  } state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    next_ptr;
  logic [MCNT_W-1:0]   meta_cnt, meta_cnt_n;

  logic [IDX_W-1:0]    cand;
  logic                pick_hit;
  logic [IDX_W-1:0]    pick_idx;
  logic [8:0]          gnt_byte;
  logic                gnt_wr;
  logic                gnt_req;
  logic                fwd;
  logic                take_grant;
  logic                end_grant;
  logic                pkt_inc;
  logic                emit_wr;
  logic [8:0]          emit_data;
  logic [DCNT_W-1:0]   drop_this;
  logic [16:0]         drop_sum;

`ifdef ARB_WATCHDOG_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]     idle_cnt, idle_cnt_n;
  logic [MCNT_W-1:0]   flush_cnt, flush_cnt_n;
  logic                flush_trig;
`endif

  function automatic logic [DCNT_W-1:0] count_ones(input logic [NUM_PORTS-1:0] v);
    logic [DCNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      n = n + DCNT_W'(v[i]);
    end
    return n;
  endfunction

  assign next_ptr = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic, forwarding mux and drop accounting
  always_comb begin
    state_n    = state;
    cand       = '0;
    pick_hit   = 1'b0;
    pick_idx   = '0;
    gnt_byte   = '0;
    gnt_wr     = iv_data_wr[grant_idx];
    gnt_req    = iv_req[grant_idx];
    fwd        = 1'b0;
    take_grant = 1'b0;
    end_grant  = 1'b0;
    pkt_inc    = 1'b0;
    emit_wr    = 1'b0;
    emit_data  = '0;
    meta_cnt_n = meta_cnt;
`ifdef ARB_WATCHDOG_EN
    idle_cnt_n  = '0;
    flush_cnt_n = flush_cnt;
    flush_trig  = 1'b0;
`endif

    // Scan downward so the candidate closest to rr_ptr is written last and wins
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_PORTS);
      if (iv_req[cand]) begin
        pick_hit = 1'b1;
        pick_idx = cand;
      end
    end

    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        gnt_byte = iv_data[9*k +: 9];
      end
    end

    case (state)
      S_IDLE: begin
        if (pick_hit) begin
          take_grant = 1'b1;
          state_n    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (gnt_wr && gnt_byte[8]) begin
          fwd        = 1'b1;
          meta_cnt_n = MCNT_W'(1);
          state_n    = (META_BYTES == 1) ? S_DATA : S_META;
        end else if (!gnt_req) begin
          end_grant = 1'b1;
          state_n   = S_IDLE;
        end
      end
      S_META: begin
        // Bit 8 is meaningless here: every byte counts as metadata
        if (gnt_wr) begin
          fwd        = 1'b1;
          meta_cnt_n = meta_cnt + 1'b1;
          if (meta_cnt_n == MCNT_W'(META_BYTES)) begin
            state_n = S_DATA;
          end
        end
`ifdef ARB_WATCHDOG_EN
        else if (idle_cnt == TO_W'(TIMEOUT)) begin
          flush_trig  = 1'b1;
          flush_cnt_n = MCNT_W'(META_BYTES) - meta_cnt;
          state_n     = S_FLUSH;
        end else begin
          idle_cnt_n = idle_cnt + 1'b1;
        end
`endif
      end
      S_DATA: begin
        if (gnt_wr) begin
          fwd = 1'b1;
          if (gnt_byte[8]) begin
            end_grant = 1'b1;
            pkt_inc   = 1'b1;
            state_n   = S_GAP;
          end
        end
`ifdef ARB_WATCHDOG_EN
        else if (idle_cnt == TO_W'(TIMEOUT)) begin
          flush_trig  = 1'b1;
          flush_cnt_n = '0;
          state_n     = S_FLUSH;
        end else begin
          idle_cnt_n = idle_cnt + 1'b1;
        end
`endif
      end
`ifdef ARB_WATCHDOG_EN
      S_FLUSH: begin
        // Pad missing metadata with zero bytes, then close with a bare last byte
        emit_wr = 1'b1;
        if (flush_cnt != '0) begin
          emit_data   = 9'h000;
          flush_cnt_n = flush_cnt - 1'b1;
        end else begin
          emit_data = 9'h100;
          end_grant = 1'b1;
          pkt_inc   = 1'b1;
          state_n   = S_GAP;
        end
      end
`endif
      S_GAP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (fwd) begin
      emit_wr   = 1'b1;
      emit_data = gnt_byte;
    end

    // Every valid byte that was not forwarded this cycle is a drop
    drop_this = count_ones(iv_data_wr) - DCNT_W'(fwd);
    drop_sum  = {1'b0, ov_drop_cnt} + 17'(drop_this);
  end

  // Grant, round-robin pointer, datapath and counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr      <= '0;
      grant_idx   <= '0;
      ov_grant    <= '0;
      meta_cnt    <= '0;
      ov_data     <= '0;
      o_data_wr   <= 1'b0;
      ov_pkt_cnt  <= '0;
      ov_drop_cnt <= '0;
    end else begin
      meta_cnt    <= meta_cnt_n;
      ov_data     <= emit_data;
      o_data_wr   <= emit_wr;
      ov_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (pkt_inc) begin
        ov_pkt_cnt <= ov_pkt_cnt + 32'd1;
      end
      if (take_grant) begin
        grant_idx <= pick_idx;
        ov_grant  <= NUM_PORTS'(1) << pick_idx;
      end else if (end_grant) begin
        ov_grant <= '0;
        rr_ptr   <= next_ptr;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  // Watchdog idle counter, pending filler count and flush pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idle_cnt      <= '0;
      flush_cnt     <= '0;
      o_flush_pulse <= 1'b0;
    end else begin
      idle_cnt      <= idle_cnt_n;
      flush_cnt     <= flush_cnt_n;
      o_flush_pulse <= flush_trig;
    end
  end
`else
  assign o_flush_pulse = 1'b0;
`endif

endmodule
